wb_mem8: RTL and testbench

Wishbone slave sitting directly downstream of the CPU's Wishbone master: it accepts 16-bit classic-cycle requests (byte lanes via `wb_sel_i`) and executes them on an external 8-bit asynchronous memory bus (SRAM/flash). A two-lane request becomes two sequential byte accesses, low lane first. Each byte access has a programmable number of strobe wait states. It signals `wb_ack_o` once the whole request is complete.

---
 rtl/wb_mem8.sv | 172 +++++++++++++++++
 tb/tb_wb_mem8.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem8.sv
// Wishbone 16-bit classic slave bridging onto an 8-bit asynchronous memory bus.
// Each selected byte lane becomes one strobed byte access, low lane first.
module wb_mem8 #(
  parameter int unsigned WAIT = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [19:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [19:0] mem_adr_o,
  input  logic [7:0]  mem_dat_i,
  output logic [7:0]  mem_dat_o,
  output logic        mem_dat_oe_o,
  output logic        mem_ce_n_o,
  output logic        mem_oe_n_o,
  output logic        mem_we_n_o
);

  localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [18:0]      adr_q, adr_d;
  logic             we_q, we_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      dat_q, dat_d;
  logic             lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        ack_q, ack_d;
  logic [15:0] rdat_q, rdat_d;
  logic [19:0] madr_q, madr_d;
  logic [7:0]  mdat_q, mdat_d;
  logic        doe_q, doe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  logic accept;
  logic active_d;

  assign accept = (state_q == S_IDLE) && wb_stb_i && wb_cyc_i;

  // State and pin registers: reset forces an idle, fully deasserted bus.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      madr_q  <= '0;
      mdat_q  <= '0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      madr_q  <= madr_d;
      mdat_q  <= mdat_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  // Latched request and sequencing state are only meaningful while busy.
  always_ff @(posedge wb_clk_i) begin
    adr_q  <= adr_d;
    we_q   <= we_d;
    sel_q  <= sel_d;
    dat_q  <= dat_d;
    lane_q <= lane_d;
    cnt_q  <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          adr_d = wb_adr_i;
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          if (wb_sel_i != 2'b00) begin
            state_d = S_ADDR;
            lane_d  = ~wb_sel_i[0];
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_ADDR: begin
        cnt_d   = CNT_W'(WAIT - 1);
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_HOLD: begin
        // A dropped cyc abandons the pending high lane and the ack.
        if (!lane_q && (sel_q == 2'b11) && wb_cyc_i) begin
          state_d = S_ADDR;
          lane_d  = 1'b1;
        end else if (wb_cyc_i) begin
          state_d = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are registered from the state being entered, so they line up with it.
  always_comb begin
    active_d = (state_d == S_ADDR) || (state_d == S_PULSE) || (state_d == S_HOLD);
    ack_d    = (state_d == S_ACK);
    ce_n_d   = ~active_d;
    doe_d    = active_d && we_d;
    oe_n_d   = ~((state_d == S_PULSE) && !we_d);
    we_n_d   = ~((state_d == S_PULSE) && we_d);
    madr_d   = madr_q;
    mdat_d   = mdat_q;
    if (state_d == S_ADDR) begin
      madr_d = {adr_d, lane_d};
      if (we_d) mdat_d = lane_d ? dat_d[15:8] : dat_d[7:0];
    end
    rdat_d = rdat_q;
    if (accept) begin
      rdat_d = '0;
    end else if ((state_q == S_PULSE) && (cnt_q == '0) && !we_q) begin
      if (lane_q) rdat_d[15:8] = mem_dat_i;
      else        rdat_d[7:0]  = mem_dat_i;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = rdat_q;
  assign mem_adr_o    = madr_q;
  assign mem_dat_o    = mdat_q;
  assign mem_dat_oe_o = doe_q;
  assign mem_ce_n_o   = ce_n_q;
  assign mem_oe_n_o   = oe_n_q;
  assign mem_we_n_o   = we_n_q;

endmodule

// File: tb/tb_wb_mem8.sv
// Directed bench for wb_mem8 (WAIT=3) with a behavioural byte memory and pin monitor.
module tb_wb_mem8;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:1] wb_adr;
  logic [15:0] wb_dat_w;
  logic [15:0] wb_dat_r;
  logic [1:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic [19:0] mem_adr;
  logic [7:0]  mem_dat_i;
  logic [7:0]  mem_dat_o;
  logic        mem_dat_oe;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  wb_mem8 #(.WAIT(3)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat_w),
    .wb_dat_o    (wb_dat_r),
    .wb_sel_i    (wb_sel),
    .wb_we_i     (wb_we),
    .wb_stb_i    (wb_stb),
    .wb_cyc_i    (wb_cyc),
    .wb_ack_o    (wb_ack),
    .mem_adr_o   (mem_adr),
    .mem_dat_i   (mem_dat_i),
    .mem_dat_o   (mem_dat_o),
    .mem_dat_oe_o(mem_dat_oe),
    .mem_ce_n_o  (mem_ce_n),
    .mem_oe_n_o  (mem_oe_n),
    .mem_we_n_o  (mem_we_n)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [logic [19:0]];

  int n_chk = 0;
  int n_bad = 0;

  // Pin monitor, sampled mid-cycle.
  int n_oe_low = 0, n_ce_low = 0, n_ack = 0;
  int cur_we = 0, cur_ce = 0, last_ce_run = 0;
  int         we_runs [$];
  logic [19:0] wr_adr [$];
  logic [7:0]  wr_dat [$];

  always @(negedge clk) begin
    mem_dat_i <= mem.exists(mem_adr) ? mem[mem_adr] : 8'h00;
    if (!mem_oe_n) n_oe_low <= n_oe_low + 1;
    if (wb_ack)    n_ack    <= n_ack + 1;
    if (!mem_ce_n) begin
      n_ce_low <= n_ce_low + 1;
      cur_ce   <= cur_ce + 1;
    end else if (cur_ce != 0) begin
      last_ce_run <= cur_ce;
      cur_ce      <= 0;
    end
    if (!mem_we_n) begin
      cur_we <= cur_we + 1;
    end else if (cur_we != 0) begin
      we_runs.push_back(cur_we);
      wr_adr.push_back(mem_adr);
      wr_dat.push_back(mem_dat_o);
      cur_we <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int s_oe, s_ce, s_ack, s_wr;
  task automatic snap();
    s_oe  = n_oe_low;
    s_ce  = n_ce_low;
    s_ack = n_ack;
    s_wr  = wr_adr.size();
  endtask

  // Present a request in the current cycle and count clocks until ack.
  task automatic run(input logic [18:0] a, input logic [1:0] s, input logic w,
                     input logic [15:0] d, output int k);
    wb_adr = a; wb_sel = s; wb_we = w; wb_dat_w = d;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!wb_ack && k < 40);
    chk("ack_seen", 32'(wb_ack), 32'd1);
  endtask

  task automatic drop();
    wb_stb = 1'b0; wb_cyc = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  int k;

  initial begin
    rst = 1'b1; wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    mem[20'h2468A] = 8'hA5;
    mem[20'h00020] = 8'h3C;
    mem[20'h00021] = 8'h7C;
    repeat (3) next_cycle();
    chk("rst_ack",  32'(wb_ack), 32'd0);
    chk("rst_dat",  32'(wb_dat_r), 32'h0);
    chk("rst_adr",  32'(mem_adr), 32'h0);
    chk("rst_mdat", 32'(mem_dat_o), 32'h0);
    chk("rst_doe",  32'(mem_dat_oe), 32'd0);
    chk("rst_strb", {29'd0, mem_ce_n, mem_oe_n, mem_we_n}, 32'h7);
    rst = 1'b0;
    next_cycle();

    // Byte read, low lane
    snap();
    run(19'h12345, 2'b01, 1'b0, 16'h0000, k);
    chk("rd_lat",  k, 6);
    chk("rd_dat",  32'(wb_dat_r), 32'h00A5);
    chk("rd_adr",  32'(mem_adr), 32'h2468A);
    chk("rd_oe",   n_oe_low - s_oe, 3);
    drop(); next_cycle();

    // Word write
    snap();
    run(19'h00010, 2'b11, 1'b1, 16'hBEEF, k);
    chk("ww_lat",  k, 11);
    chk("ww_cnt",  wr_adr.size() - s_wr, 2);
    if (wr_adr.size() - s_wr == 2) begin
      chk("ww_a0", 32'(wr_adr[s_wr]),   32'h00020);
      chk("ww_d0", 32'(wr_dat[s_wr]),   32'hEF);
      chk("ww_w0", we_runs[s_wr],       3);
      chk("ww_a1", 32'(wr_adr[s_wr+1]), 32'h00021);
      chk("ww_d1", 32'(wr_dat[s_wr+1]), 32'hBE);
      chk("ww_w1", we_runs[s_wr+1],     3);
    end
    drop(); next_cycle();
    chk("ww_ce_run", last_ce_run, 10);
    chk("ww_ackw",   n_ack - s_ack, 1);
    chk("ww_oe",     n_oe_low - s_oe, 0);

    // Odd byte read
    snap();
    run(19'h00010, 2'b10, 1'b0, 16'h0000, k);
    chk("odd_lat", k, 6);
    chk("odd_dat", 32'(wb_dat_r), 32'h7C00);
    chk("odd_adr", 32'(mem_adr), 32'h00021);
    chk("odd_ce",  n_ce_low - s_ce, 5);
    drop(); next_cycle();

    // Empty lane select
    snap();
    run(19'h00010, 2'b00, 1'b0, 16'h0000, k);
    chk("sel0_lat", k, 1);
    drop(); next_cycle();
    chk("sel0_ce",  n_ce_low - s_ce, 0);
    chk("sel0_ack", n_ack - s_ack, 1);

    // Reset during first strobe of a word write
    snap();
    wb_adr = 19'h00010; wb_sel = 2'b11; wb_we = 1'b1; wb_dat_w = 16'h1234;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    next_cycle();
    next_cycle();
    chk("rs_inpulse", 32'(mem_we_n), 32'd0);
    rst = 1'b1; drop();
    next_cycle();
    chk("rs_strb", {29'd0, mem_ce_n, mem_oe_n, mem_we_n}, 32'h7);
    chk("rs_doe",  32'(mem_dat_oe), 32'd0);
    chk("rs_ack",  32'(wb_ack), 32'd0);
    rst = 1'b0;
    repeat (4) next_cycle();
    chk("rs_noack", n_ack - s_ack, 0);
    run(19'h12345, 2'b01, 1'b0, 16'h0000, k);
    chk("rs_rd_lat", k, 6);
    chk("rs_rd_dat", 32'(wb_dat_r), 32'h00A5);
    drop(); next_cycle();

    // cyc dropped during the low lane of a word read
    snap();
    wb_adr = 19'h00010; wb_sel = 2'b11; wb_we = 1'b0; wb_dat_w = 16'h0000;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    next_cycle();
    drop();
    repeat (4) next_cycle();
    chk("ab_hold_ce", 32'(mem_ce_n), 32'd0);
    next_cycle();
    chk("ab_ce_off", 32'(mem_ce_n), 32'd1);
    chk("ab_dat",    32'(wb_dat_r), 32'h003C);
    chk("ab_oe",     n_oe_low - s_oe, 3);
    chk("ab_noack",  n_ack - s_ack, 0);
    // New request straight away: must be accepted, proving the FSM is idle
    run(19'h12345, 2'b01, 1'b0, 16'h0000, k);
    chk("ab_next_lat", k, 6);
    // Back-to-back: next request presented during the ack cycle
    run(19'h00010, 2'b10, 1'b0, 16'h0000, k);
    chk("b2b_lat", k, 7);
    chk("b2b_dat", 32'(wb_dat_r), 32'h7C00);
    drop(); next_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
